// File: rtl/zbt_arbiter_pkg.sv
// Shared parameters and grant encoding for the ZBT SRAM arbiter.
`ifndef LOG_ADDR
`define LOG_ADDR 19
`endif
`ifndef LOG_MEM
`define LOG_MEM 36
`endif

package zbt_arbiter_pkg;

    localparam int unsigned ZBT_ADDR_W     = `LOG_ADDR;
    localparam int unsigned ZBT_DATA_W     = `LOG_MEM;
    localparam int unsigned ZBT_TAG_W      = 4;
    localparam int unsigned ZBT_STARVE_MAX = 8;
    // Grant cycle to rd_valid: one issue register, two SRAM stages, one capture register.
    localparam int unsigned RD_LAT         = 4;

    typedef enum logic [1:0] {
        GntNone,
        GntWrite,
        GntRead
    } gnt_e;

endpackage

// File: rtl/zbt_rd_tracker.sv
// Valid+tag delay line matching the SRAM read pipeline, plus the read-return output register.
module zbt_rd_tracker
    import zbt_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = ZBT_DATA_W,
    parameter int unsigned TAG_W  = ZBT_TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]  rd_tag_o
);

    localparam int unsigned Depth = RD_LAT - 1;

    logic [Depth-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [Depth];
    logic [TAG_W-1:0] tag_d [Depth];
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    always_comb begin
        vld_d    = {vld_q[Depth-2:0], issue_i};
        tag_d[0] = tag_i;
        for (int i = 1; i < Depth; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        // Last stage lines up with mem_data; data/tag hold while no read returns.
        out_vld_d  = vld_q[Depth-1];
        out_data_d = vld_q[Depth-1] ? mem_data_i : out_data_q;
        out_tag_d  = vld_q[Depth-1] ? tag_q[Depth-1] : out_tag_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q      <= '0;
            for (int i = 0; i < Depth; i++) begin
                tag_q[i] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            vld_q      <= vld_d;
            for (int i = 0; i < Depth; i++) begin
                tag_q[i] <= tag_d[i];
            end
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    assign rd_valid_o = out_vld_q;
    assign rd_data_o  = out_data_q;
    assign rd_tag_o   = out_tag_q;

endmodule

// File: rtl/zbt_arbiter.sv
// ZBT SRAM front end: write/read client arbitration with starvation guard and tagged,
// in-order read return.
module zbt_arbiter
    import zbt_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ZBT_ADDR_W,
    parameter int unsigned DATA_W     = ZBT_DATA_W,
    parameter int unsigned TAG_W      = ZBT_TAG_W,
    parameter int unsigned STARVE_MAX = ZBT_STARVE_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag_out,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    gnt_e              gnt;
    logic [CntW-1:0]   starve_q, starve_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_write_q, mem_write_d;

    always_comb begin
        gnt = GntNone;
        if (!reset) begin
            if (wr_req && rd_req) begin
                gnt = (starve_q == CntW'(STARVE_MAX)) ? GntWrite : GntRead;
            end else if (wr_req) begin
                gnt = GntWrite;
            end else if (rd_req) begin
                gnt = GntRead;
            end
        end
    end

    assign wr_ack = (gnt == GntWrite);
    assign rd_ack = (gnt == GntRead);

    always_comb begin
        starve_d    = starve_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        unique case (gnt)
            GntWrite: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_write_d = wr_data;
            end
            GntRead:  mem_addr_d = rd_addr;
            default:  ;
        endcase
        // Only reads that bypass a waiting write count towards starvation.
        if (!wr_req || gnt == GntWrite) begin
            starve_d = '0;
        end else if (gnt == GntRead && starve_q != CntW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q    <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
        end else begin
            starve_q    <= starve_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;

    zbt_rd_tracker #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_rd_tracker (
        .clock      (clock),
        .reset      (reset),
        .issue_i    (rd_ack),
        .tag_i      (rd_tag),
        .mem_data_i (mem_data),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_tag_o   (rd_tag_out)
    );

endmodule

// File: tb/tb_zbt_arbiter.sv
// Directed bench for zbt_arbiter with a two-stage pipelined SRAM model attached.
module tb_zbt_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 36;
    localparam int unsigned TW = 4;

    logic          clock;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [TW-1:0] rd_tag;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [TW-1:0] rd_tag_out;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write;
    logic [DW-1:0] mem_data;

    int passed = 0;
    int total  = 0;

    zbt_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TAG_W      (TW),
        .STARVE_MAX (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_tag     (rd_tag),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_tag_out (rd_tag_out),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_data   (mem_data)
    );

    // SRAM model: address sampled at the edge ending its cycle, data out one edge later.
    logic [DW-1:0] sram [1024];
    logic [DW-1:0] sram_q;
    logic          sram_clr;

    always @(posedge clock) begin
        if (sram_clr) begin
            for (int i = 0; i < 1024; i++) sram[i] <= '0;
        end else if (mem_wr) begin
            sram[mem_addr[9:0]] <= mem_write;
        end
        sram_q   <= sram[mem_addr[9:0]];
        mem_data <= sram_q;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic [TW-1:0] rd_tag;
        logic          exp_wr_ack;
        logic          exp_rd_ack;
        logic          exp_mem_wr;
        logic [AW-1:0] exp_mem_addr;
        logic [DW-1:0] exp_mem_write;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        sram_clr = 1'b1;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        tick();
        reset    = 1'b0;
        sram_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 19'h0,  36'h0,         1'b0, 19'h0,  4'd0, 1'b0, 1'b0,
                    1'b0, 19'h0,  36'h0};
        vecs[1] = '{1'b1, 19'h10, 36'h123456789, 1'b0, 19'h0,  4'd0, 1'b1, 1'b0,
                    1'b1, 19'h10, 36'h123456789};
        vecs[2] = '{1'b0, 19'h0,  36'h0,         1'b1, 19'h10, 4'd3, 1'b0, 1'b1,
                    1'b0, 19'h10, 36'h123456789};
        vecs[3] = '{1'b1, 19'h30, 36'h55,        1'b1, 19'h20, 4'd5, 1'b0, 1'b1,
                    1'b0, 19'h20, 36'h123456789};
        vecs[4] = '{1'b1, 19'h30, 36'h55,        1'b0, 19'h0,  4'd0, 1'b1, 1'b0,
                    1'b1, 19'h30, 36'h55};
        vecs[5] = '{1'b0, 19'h0,  36'h0,         1'b0, 19'h0,  4'd0, 1'b0, 1'b0,
                    1'b0, 19'h30, 36'h55};

        // Reset held with both requests up: no grant, all state cleared.
        reset    = 1'b1;
        sram_clr = 1'b1;
        wr_req   = 1'b1;
        rd_req   = 1'b1;
        wr_addr  = 19'h7;
        wr_data  = 36'h9;
        rd_addr  = 19'h8;
        rd_tag   = 4'd1;
        tick();
        tick();
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_tag_out", rd_tag_out, 0);
        reset    = 1'b0;
        sram_clr = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;

        // Grant and issue vectors.
        for (int i = 0; i < 6; i++) begin
            wr_req  = vecs[i].wr_req;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            rd_req  = vecs[i].rd_req;
            rd_addr = vecs[i].rd_addr;
            rd_tag  = vecs[i].rd_tag;
            #1;
            chk($sformatf("vec%0d_wr_ack", i), wr_ack, vecs[i].exp_wr_ack);
            chk($sformatf("vec%0d_rd_ack", i), rd_ack, vecs[i].exp_rd_ack);
            tick();
            chk($sformatf("vec%0d_mem_wr", i), mem_wr, vecs[i].exp_mem_wr);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_mem_addr);
            chk($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].exp_mem_write);
        end

        // Write in cycle 0, read same address in cycle 1, data back in cycle 5.
        do_reset();
        wr_req  = 1'b1;
        wr_addr = 19'h10;
        wr_data = 36'h123456789;
        #1;
        chk("wr_then_rd_wr_ack", wr_ack, 1);
        tick();
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 19'h10;
        rd_tag  = 4'd3;
        #1;
        chk("wr_then_rd_rd_ack", rd_ack, 1);
        tick();
        rd_req = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            #1;
            chk($sformatf("lat_rd_valid_c%0d", c), rd_valid, (c == 5));
            if (c == 5) begin
                chk("lat_rd_data", rd_data, 36'h123456789);
                chk("lat_rd_tag", rd_tag_out, 3);
            end
            tick();
        end
        chk("hold_rd_valid", rd_valid, 0);
        chk("hold_rd_data", rd_data, 36'h123456789);
        chk("hold_rd_tag", rd_tag_out, 3);

        // Fill addresses 0..7, then stream reads back to back.
        for (int i = 0; i < 8; i++) begin
            wr_req  = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(32'h100 + i);
            #1;
            chk($sformatf("fill_wr_ack%0d", i), wr_ack, 1);
            tick();
        end
        wr_req = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rd_req  = (c < 8);
            rd_addr = AW'(c);
            rd_tag  = TW'(c);
            #1;
            if (c < 8) chk($sformatf("b2b_rd_ack%0d", c), rd_ack, 1);
            chk($sformatf("b2b_rd_valid%0d", c), rd_valid, (c >= 4 && c < 12));
            if (c >= 4 && c < 12) begin
                chk($sformatf("b2b_tag%0d", c), rd_tag_out, c - 4);
                chk($sformatf("b2b_data%0d", c), rd_data, 32'h100 + c - 4);
            end
            tick();
        end
        rd_req = 1'b0;

        // Continuous contention: writes forced on cycles 8, 17, 26.
        wr_req  = 1'b1;
        wr_addr = 19'h40;
        wr_data = 36'h77;
        rd_req  = 1'b1;
        rd_addr = 19'h5;
        rd_tag  = 4'hA;
        for (int c = 0; c < 27; c++) begin
            logic exp_w;
            exp_w = (c == 8 || c == 17 || c == 26);
            #1;
            chk($sformatf("starve_wr_ack%0d", c), wr_ack, exp_w);
            chk($sformatf("starve_rd_ack%0d", c), rd_ack, !exp_w);
            tick();
        end
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Drain, then idle: nothing issued, address and data held.
        for (int c = 0; c < 6; c++) tick();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("idle_mem_wr%0d", c), mem_wr, 0);
            chk($sformatf("idle_rd_valid%0d", c), rd_valid, 0);
            chk($sformatf("idle_mem_addr%0d", c), mem_addr, 19'h40);
            tick();
        end
        chk("idle_mem_write", mem_write, 36'h77);
        chk("idle_rd_data", rd_data, 36'h105);

        // Reads in cycles 0-2, reset with requests in cycle 3.
        for (int c = 0; c < 3; c++) begin
            rd_req  = 1'b1;
            rd_addr = AW'(c + 1);
            rd_tag  = TW'(c + 1);
            #1;
            chk($sformatf("mid_rd_ack%0d", c), rd_ack, 1);
            tick();
        end
        reset  = 1'b1;
        wr_req = 1'b1;
        #1;
        chk("mid_rst_rd_ack", rd_ack, 0);
        chk("mid_rst_wr_ack", wr_ack, 0);
        tick();
        reset  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("post_rst_mem_wr", mem_wr, 0);
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_mem_write", mem_write, 0);
        chk("post_rst_rd_data", rd_data, 0);
        chk("post_rst_rd_tag", rd_tag_out, 0);
        for (int c = 4; c <= 8; c++) begin
            chk($sformatf("post_rst_rd_valid_c%0d", c), rd_valid, 0);
            tick();
        end

        // Read-after-write on 0x20: read before the write sees 0, read after sees new data.
        for (int c = 0; c < 8; c++) begin
            wr_req  = (c == 1);
            wr_addr = 19'h20;
            wr_data = 36'hAAAA;
            rd_req  = (c == 0 || c == 2);
            rd_addr = 19'h20;
            rd_tag  = (c == 0) ? 4'd1 : 4'd2;
            #1;
            if (c < 3) begin
                chk($sformatf("raw_wr_ack%0d", c), wr_ack, (c == 1));
                chk($sformatf("raw_rd_ack%0d", c), rd_ack, (c != 1));
            end
            chk($sformatf("raw_rd_valid%0d", c), rd_valid, (c == 4 || c == 6));
            if (c == 4) begin
                chk("raw_old_data", rd_data, 0);
                chk("raw_old_tag", rd_tag_out, 1);
            end
            if (c == 6) begin
                chk("raw_new_data", rd_data, 36'hAAAA);
                chk("raw_new_tag", rd_tag_out, 2);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
